down_counter8: RTL and testbench
================================

# down_counter8

Loadable down-counter/timer, the counting-down counterpart of the team's 8-bit up-counter. It shares the same load/enable/data control interface.
- Load a start value, decrement once per enabled clock, flag terminal count.
- Used as a programmable delay/timeout generator beside the up-counter in lab datapaths.
- Optionally reloads itself for periodic ticks.

## Interface
- WIDTH, 8, counter and data width in bits (≥2)
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  reset; asynchronous, active-high
- load_i  input  1  load data_i as start/reload value; priority over en_i
- en_i  input  1  count enable; decrement on enabled edges only
- data_i  input  WIDTH  start value, sampled when load_i=1
- cnt_o  output  WIDTH  current count, registered
- tc_o  output  1  terminal-count pulse, one cycle, registered
- busy_o  output  1  high while in RUN
- done_o  output  1  high while in DONE

## Operation
- Internal registers: cnt, reload (WIDTH bits), state ∈ {IDLE, RUN, DONE}, tc.
- Reset (async, any time): state=IDLE, cnt_o=0, reload=0, tc_o=0, busy_o=0, done_o=0. A reset mid-count discards the count immediately, with no tc pulse.
- Loading:
  - load_i=1, any state, data_i≠0: cnt←data_i, reload←data_i, state→RUN, tc_o←0.
  - load_i=1, data_i=0: cnt←0, reload←0, state→IDLE, no tc pulse.
- RUN:
  - en_i=1, load_i=0, cnt>1: cnt←cnt−1.
  - en_i=1, load_i=0, cnt==1: terminal event. tc_o←1 for exactly one cycle. Next state per Configuration.
  - en_i=0: hold cnt and state.
- DONE: cnt holds 0. en_i is ignored. Only load_i or reset leave DONE.
- IDLE: cnt holds 0. en_i is ignored.
- load_i and the terminal event on the same edge: load wins, tc_o=0.
- Arithmetic: unsigned. cnt never decrements below 0 and never wraps to all-ones.
- busy_o = (state==RUN). done_o = (state==DONE). Both are registered alongside state.

## Timing
- Every output changes only on rising clk_i, or asynchronously on rst_i.
- Load edge N: cnt_o=data_i and busy_o=1 visible after edge N. First decrement at the first enabled edge after N.
- Start value V with en_i held high: the terminal event occurs on the V-th enabled edge after the load edge.
  - Non-reload: cnt_o=0 and done_o=1 after that edge.
- tc_o is asserted in the same cycle cnt_o shows its post-terminal value (0, or reload value). It deasserts on the next edge unconditionally.
- Stalls (en_i=0) extend latency one cycle each. tc_o is never asserted during a stall.

## Configuration
- Macro DOWN_COUNTER_AUTORELOAD_EN.
- Undefined (default): on the terminal event, cnt←0, state→DONE, busy_o→0, done_o→1. A single-shot timer.
- Defined: on the terminal event, cnt←reload, state stays RUN, busy_o stays 1, and done_o is never asserted.
  - cnt_o never shows 0 while running.
  - tc_o pulses every `reload` enabled cycles.
  - A load_i during RUN replaces reload for subsequent periods.

## Test plan
- Reset: assert rst_i mid-cycle with no clock edge → cnt_o=0, tc_o=0, busy_o=0, done_o=0 immediately.
- Single-shot: load 8'd5, en_i=1 continuously.
  - cnt_o sequence 5,4,3,2,1,0.
  - tc_o=1 only in the cycle cnt_o first reads 0.
  - Then done_o=1 and cnt_o stays 0 for 10 more cycles.
- Stall: load 8'd3, toggle en_i 1,0,0,1,1.
  - cnt_o sequence 3,2,2,2,1,0.
  - tc_o pulses once, 5 edges after load.
- Collision and zero load:
  - Load 8'd2, count to 1, then assert load_i with data_i=8'd7 together with en_i → cnt_o=7, tc_o=0, busy_o=1.
  - Load 8'd0 → cnt_o=0, state IDLE, no tc_o.
- Reset mid-operation: load 8'hFF, count 100 cycles (cnt_o=8'd155), assert rst_i → all outputs 0, and no tc_o after release.
- Autoreload (DOWN_COUNTER_AUTORELOAD_EN defined): load 8'd4, en_i=1 for 12 cycles.
  - cnt_o 4,3,2,1,4,3,2,1,4,…
  - tc_o pulses on edges 4, 8, 12.
  - done_o stays 0.

Source files
------------

// File: rtl/down_counter8_if.sv
// Control/status bundle for down_counter8: load/enable/data in, count and status flags out.
interface down_counter8_if #(
   parameter int WIDTH = 8
);
   logic             load_i;
   logic             en_i;
   logic [WIDTH-1:0] data_i;
   logic [WIDTH-1:0] cnt_o;
   logic             tc_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      output load_i, en_i, data_i,
      input  cnt_o, tc_o, busy_o, done_o
   );

   modport slave (
      input  load_i, en_i, data_i,
      output cnt_o, tc_o, busy_o, done_o
   );
endinterface

// File: rtl/down_counter8.sv
// Loadable down-counter/timer with one-cycle terminal-count pulse.
// Define DOWN_COUNTER_AUTORELOAD_EN to reload the start value on terminal count (periodic ticks).
module down_counter8 #(
   parameter int WIDTH = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   down_counter8_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tc_d    = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_d = reload_q;
`endif
      if (bus.load_i) begin
         // Load beats a coincident terminal event; a zero load parks the timer in IDLE.
         cnt_d   = bus.data_i;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
         reload_d = bus.data_i;
`endif
         state_d = (bus.data_i != ZERO) ? S_RUN : S_IDLE;
      end else begin
         case (state_q)
            S_RUN: begin
               if (bus.en_i) begin
                  if (cnt_q > ONE) begin
                     cnt_d = cnt_q - ONE;
                  end else if (cnt_q == ONE) begin
                     tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                     cnt_d = reload_q;
`else
                     cnt_d   = ZERO;
                     state_d = S_DONE;
`endif
                  end
               end
            end
            S_DONE:  cnt_d = ZERO;
            S_IDLE:  cnt_d = ZERO;
            default: begin
               cnt_d   = ZERO;
               state_d = S_IDLE;
            end
         endcase
      end
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= ZERO;
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
         reload_q <= ZERO;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign bus.cnt_o  = cnt_q;
   assign bus.tc_o   = tc_q;
   assign bus.busy_o = busy_q;
   assign bus.done_o = done_q;

endmodule

// File: tb/tb_down_counter8.sv
// Scoreboard bench for down_counter8: expectations queued per driven cycle, popped after the edge.
module tb_down_counter8;

   typedef logic [10:0] obs_t;  // {cnt[7:0], tc, busy, done}

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   obs_t sb[$];

   down_counter8_if #(.WIDTH(8)) bus ();

   down_counter8 #(.WIDTH(8)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   function automatic obs_t pk(input logic [7:0] c, input logic t, input logic b, input logic d);
      return {c, t, b, d};
   endfunction

   task automatic drv(input logic l, input logic e, input logic [7:0] d);
      bus.load_i = l;
      bus.en_i   = e;
      bus.data_i = d;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      obs_t got, exp;
      drv(1'b0, 1'b0, 8'd0);
      tick();
      tick();
      sb.push_back(pk(8'd0, 1'b0, 1'b0, 1'b0));
      got = {bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o};
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL reset_state: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                  got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
      end
      rst_i = 1'b0;
      tick();
      // Load a value, then assert reset between edges and look before the next edge.
      drv(1'b1, 1'b0, 8'd9);
      tick();
      drv(1'b0, 1'b1, 8'd0);
      #2 rst_i = 1'b1;
      #1;
      sb.push_back(pk(8'd0, 1'b0, 1'b0, 1'b0));
      got = {bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o};
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL reset_async: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                  got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
      end
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_single_shot();
      obs_t got, exp;
      for (int i = 0; i < 16; i++) begin
         if (i == 0) drv(1'b1, 1'b1, 8'd5);
         else        drv(1'b0, 1'b1, 8'd0);
         if (i < 5)       sb.push_back(pk(8'(5 - i), 1'b0, 1'b1, 1'b0));
         else if (i == 5) sb.push_back(pk(8'd0, 1'b1, 1'b0, 1'b1));
         else             sb.push_back(pk(8'd0, 1'b0, 1'b0, 1'b1));
         tick();
         got = {bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o};
         exp = sb.pop_front();
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL single_shot step %0d: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                     i, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
         end
      end
   endtask

   task automatic test_stall();
      obs_t got, exp;
      logic en_seq [7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [7:0] c_seq [7] = '{8'd3, 8'd2, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0};
      for (int i = 0; i < 7; i++) begin
         drv(i == 0, en_seq[i], (i == 0) ? 8'd3 : 8'd0);
         sb.push_back(pk(c_seq[i], i == 5, i < 5, i >= 5));
         tick();
         got = {bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o};
         exp = sb.pop_front();
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL stall step %0d: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                     i, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
         end
      end
   endtask

   task automatic test_collision_zero();
      obs_t got, exp;
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: begin drv(1'b1, 1'b0, 8'd2); sb.push_back(pk(8'd2, 1'b0, 1'b1, 1'b0)); end
            1: begin drv(1'b0, 1'b1, 8'd0); sb.push_back(pk(8'd1, 1'b0, 1'b1, 1'b0)); end
            2: begin drv(1'b1, 1'b1, 8'd7); sb.push_back(pk(8'd7, 1'b0, 1'b1, 1'b0)); end
            3: begin drv(1'b0, 1'b1, 8'd0); sb.push_back(pk(8'd6, 1'b0, 1'b1, 1'b0)); end
            4: begin drv(1'b1, 1'b1, 8'd0); sb.push_back(pk(8'd0, 1'b0, 1'b0, 1'b0)); end
            default: begin drv(1'b0, 1'b1, 8'd0); sb.push_back(pk(8'd0, 1'b0, 1'b0, 1'b0)); end
         endcase
         tick();
         got = {bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o};
         exp = sb.pop_front();
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL collision_zero step %0d: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                     i, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      obs_t got, exp;
      for (int i = 0; i <= 100; i++) begin
         drv(i == 0, i != 0, (i == 0) ? 8'hFF : 8'd0);
         sb.push_back(pk(8'(255 - i), 1'b0, 1'b1, 1'b0));
         tick();
         got = {bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o};
         exp = sb.pop_front();
         if (i == 1 || i == 50 || i == 100) begin
            n_chk++;
            if (got !== exp) begin
               n_fail++;
               $display("FAIL reset_mid count %0d: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                        i, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
            end
         end
      end
      #2 rst_i = 1'b1;
      #1;
      sb.push_back(pk(8'd0, 1'b0, 1'b0, 1'b0));
      got = {bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o};
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL reset_mid async: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                  got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
      end
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drv(1'b0, 1'b1, 8'd0);
         sb.push_back(pk(8'd0, 1'b0, 1'b0, 1'b0));
         tick();
         got = {bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o};
         exp = sb.pop_front();
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_mid release step %0d: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                     i, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
         end
      end
   endtask

`ifdef DOWN_COUNTER_AUTORELOAD_EN
   task automatic test_autoreload();
      obs_t got, exp;
      for (int k = 0; k <= 12; k++) begin
         drv(k == 0, 1'b1, (k == 0) ? 8'd4 : 8'd0);
         if (k == 0)          sb.push_back(pk(8'd4, 1'b0, 1'b1, 1'b0));
         else if (k % 4 == 0) sb.push_back(pk(8'd4, 1'b1, 1'b1, 1'b0));
         else                 sb.push_back(pk(8'(4 - k % 4), 1'b0, 1'b1, 1'b0));
         tick();
         got = {bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o};
         exp = sb.pop_front();
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL autoreload edge %0d: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                     k, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
         end
      end
      // A load while running replaces the period.
      for (int k = 0; k <= 4; k++) begin
         drv(k == 0, 1'b1, (k == 0) ? 8'd2 : 8'd0);
         if (k == 0)          sb.push_back(pk(8'd2, 1'b0, 1'b1, 1'b0));
         else if (k % 2 == 0) sb.push_back(pk(8'd2, 1'b1, 1'b1, 1'b0));
         else                 sb.push_back(pk(8'd1, 1'b0, 1'b1, 1'b0));
         tick();
         got = {bus.cnt_o, bus.tc_o, bus.busy_o, bus.done_o};
         exp = sb.pop_front();
         n_chk++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL autoreload_newload edge %0d: got cnt=%0d tc=%b busy=%b done=%b, expected cnt=%0d tc=%b busy=%b done=%b",
                     k, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
         end
      end
   endtask
`endif

   initial begin
      drv(1'b0, 1'b0, 8'd0);
      test_reset();
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      test_autoreload();
`else
      test_single_shot();
      test_stall();
`endif
      test_collision_zero();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
